target_box_extract: RTL and testbench

Streaming bounding-box extractor for the multi-target detection pipeline. Sits directly downstream of the frame-difference/binarisation stage and consumes its 1-bit foreground stream, using the same vsync/href/clken video timing as the RGB stimulus path. It clusters foreground pixels into up to MAX_TARGET axis-aligned boxes per frame. At frame end it emits the box list for the overlay stage that draws boxes onto the RGB output.

---
 rtl/target_box_extract.sv | 206 ++++++++++++++++++++
 tb/tb_target_box_extract.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_box_extract.sv
// Streaming bounding-box extractor: clusters a 1-bit foreground stream into
// up to MAX_TARGET boxes per frame and emits the box list after each frame.
module target_box_extract #(
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480,
    parameter int MAX_TARGET = 4,
    parameter int DIST_TH    = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic        per_img_bit,
    output logic        box_valid,
    output logic [2:0]  box_idx,
    output logic [10:0] box_xmin,
    output logic [10:0] box_xmax,
    output logic [10:0] box_ymin,
    output logic [10:0] box_ymax,
    output logic        box_done,
    output logic [3:0]  box_cnt,
    output logic        box_overflow
);
    localparam int IW = (MAX_TARGET > 1) ? $clog2(MAX_TARGET) : 1;

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    logic [10:0] x, y;
    logic        vs_d, hs_d;
    logic        vs_fall, vs_rise, hs_fall, pix_en;

    logic [MAX_TARGET-1:0] sv;
    logic [10:0] sx0 [MAX_TARGET];
    logic [10:0] sx1 [MAX_TARGET];
    logic [10:0] sy0 [MAX_TARGET];
    logic [10:0] sy1 [MAX_TARGET];
    logic        ovf;

    logic [MAX_TARGET-1:0] nv;
    logic [10:0] nx0 [MAX_TARGET];
    logic [10:0] nx1 [MAX_TARGET];
    logic [10:0] ny0 [MAX_TARGET];
    logic [10:0] ny1 [MAX_TARGET];
    logic        novf;

    logic [MAX_TARGET-1:0] hit;
    logic [IW-1:0] hit_idx, free_idx, nidx;
    logic          any_hit, any_free;
    logic [3:0]    vcnt;

    state_t        state;
    logic [IW-1:0] idx;

    assign vs_fall = vs_d & ~per_frame_vsync;
    assign vs_rise = ~vs_d & per_frame_vsync;
    assign hs_fall = hs_d & ~per_frame_href;
    assign pix_en  = per_frame_href & per_frame_clken & per_frame_vsync
                   & ({1'b0, x} < 12'(IMG_HDISP))
                   & ({1'b0, y} < 12'(IMG_VDISP));
    assign nidx    = idx + 1'b1;

    // x >= sat0(xmin-DIST_TH) is evaluated as x+DIST_TH >= xmin to avoid wrap
    always_comb begin
        hit      = '0;
        any_hit  = 1'b0;
        hit_idx  = '0;
        any_free = 1'b0;
        free_idx = '0;
        vcnt     = '0;
        for (int s = MAX_TARGET - 1; s >= 0; s--) begin
            hit[s] = sv[s]
                   && ({1'b0, x} + 12'(DIST_TH) >= {1'b0, sx0[s]})
                   && ({1'b0, x} <= {1'b0, sx1[s]} + 12'(DIST_TH))
                   && ({1'b0, y} <= {1'b0, sy1[s]} + 12'(DIST_TH));
            if (hit[s]) begin
                any_hit = 1'b1;
                hit_idx = IW'(s);
            end
            if (!sv[s]) begin
                any_free = 1'b1;
                free_idx = IW'(s);
            end
        end
        for (int s = 0; s < MAX_TARGET; s++) begin
            vcnt = vcnt + 4'(nv[s]);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            x    <= '0;
            y    <= '0;
            vs_d <= 1'b0;
            hs_d <= 1'b0;
            sv   <= '0;
            nv   <= '0;
            ovf  <= 1'b0;
            novf <= 1'b0;
            for (int s = 0; s < MAX_TARGET; s++) begin
                sx0[s] <= '0; sx1[s] <= '0; sy0[s] <= '0; sy1[s] <= '0;
                nx0[s] <= '0; nx1[s] <= '0; ny0[s] <= '0; ny1[s] <= '0;
            end
        end else begin
            vs_d <= per_frame_vsync;
            hs_d <= per_frame_href;
            if (vs_rise) begin
                x <= '0;
                y <= '0;
            end else if (hs_fall) begin
                x <= '0;
                if (y != '1) y <= y + 1'b1;
            end else if (per_frame_href && per_frame_clken && x != '1) begin
                x <= x + 1'b1;
            end
            // frame end: freeze results and start the next frame from empty
            if (vs_fall) begin
                nv   <= sv;
                novf <= ovf;
                sv   <= '0;
                ovf  <= 1'b0;
                for (int s = 0; s < MAX_TARGET; s++) begin
                    nx0[s] <= sx0[s]; nx1[s] <= sx1[s];
                    ny0[s] <= sy0[s]; ny1[s] <= sy1[s];
                    sx0[s] <= '0; sx1[s] <= '0; sy0[s] <= '0; sy1[s] <= '0;
                end
            end else if (pix_en && per_img_bit) begin
                if (any_hit) begin
                    if (x < sx0[hit_idx]) sx0[hit_idx] <= x;
                    if (x > sx1[hit_idx]) sx1[hit_idx] <= x;
                    sy1[hit_idx] <= y;
                end else if (any_free) begin
                    sv[free_idx]  <= 1'b1;
                    sx0[free_idx] <= x;
                    sx1[free_idx] <= x;
                    sy0[free_idx] <= y;
                    sy1[free_idx] <= y;
                end else begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // record 0 is taken from the live slots as they are being snapshotted
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            idx          <= '0;
            box_valid    <= 1'b0;
            box_idx      <= '0;
            box_xmin     <= '0;
            box_xmax     <= '0;
            box_ymin     <= '0;
            box_ymax     <= '0;
            box_done     <= 1'b0;
            box_cnt      <= '0;
            box_overflow <= 1'b0;
        end else begin
            box_valid    <= 1'b0;
            box_idx      <= '0;
            box_xmin     <= '0;
            box_xmax     <= '0;
            box_ymin     <= '0;
            box_ymax     <= '0;
            box_done     <= 1'b0;
            box_cnt      <= '0;
            box_overflow <= 1'b0;
            if (vs_fall) begin
                state     <= EMIT;
                idx       <= '0;
                box_valid <= sv[0];
                if (sv[0]) begin
                    box_xmin <= sx0[0];
                    box_xmax <= sx1[0];
                    box_ymin <= sy0[0];
                    box_ymax <= sy1[0];
                end
            end else begin
                unique case (state)
                    EMIT: begin
                        if (idx == IW'(MAX_TARGET - 1)) begin
                            state        <= DONE;
                            box_done     <= 1'b1;
                            box_cnt      <= vcnt;
                            box_overflow <= novf;
                        end else begin
                            idx       <= nidx;
                            box_idx   <= 3'(nidx);
                            box_valid <= nv[nidx];
                            if (nv[nidx]) begin
                                box_xmin <= nx0[nidx];
                                box_xmax <= nx1[nidx];
                                box_ymin <= ny0[nidx];
                                box_ymax <= ny1[nidx];
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    IDLE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_target_box_extract.sv
// Randomised bench for target_box_extract: raster frames are generated from a
// pixel set and the emitted box list is compared with a clustering model.
module tb_target_box_extract;
    localparam int HD = 640;
    localparam int VD = 480;
    localparam int MT = 4;
    localparam int DT = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        vs = 1'b0, hr = 1'b0, ce = 1'b0, px_bit = 1'b0;
    logic        box_valid, box_done, box_overflow;
    logic [2:0]  box_idx;
    logic [10:0] box_xmin, box_xmax, box_ymin, box_ymax;
    logic [3:0]  box_cnt;

    int checks = 0;
    int errors = 0;

    bit fg[int];
    int rowmax[1024];
    int maxrow;

    int ev[MT], ex0[MT], ex1[MT], ey0[MT], ey1[MT];
    int ecnt, eovf;

    target_box_extract #(
        .IMG_HDISP(HD), .IMG_VDISP(VD), .MAX_TARGET(MT), .DIST_TH(DT)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .per_frame_vsync(vs), .per_frame_href(hr),
        .per_frame_clken(ce), .per_img_bit(px_bit),
        .box_valid(box_valid), .box_idx(box_idx),
        .box_xmin(box_xmin), .box_xmax(box_xmax),
        .box_ymin(box_ymin), .box_ymax(box_ymax),
        .box_done(box_done), .box_cnt(box_cnt),
        .box_overflow(box_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    task automatic clear_fg();
        fg.delete();
        foreach (rowmax[r]) rowmax[r] = -1;
        maxrow = 0;
    endtask

    task automatic set_px(int x, int y);
        fg[y * 4096 + x] = 1'b1;
        if (x > rowmax[y]) rowmax[y] = x;
        if (y > maxrow) maxrow = y;
    endtask

    task automatic add_rect(int x0, int x1, int y0, int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) set_px(x, y);
    endtask

    // Greedy clustering in raster order: first box within DT grows, else a
    // new box opens, else the pixel is lost and the frame is flagged.
    task automatic run_model();
        for (int s = 0; s < MT; s++) begin
            ev[s] = 0; ex0[s] = 0; ex1[s] = 0; ey0[s] = 0; ey1[s] = 0;
        end
        eovf = 0;
        foreach (fg[k]) begin
            int x, y, lo, placed;
            x = k % 4096;
            y = k / 4096;
            if (x < HD && y < VD) begin
                placed = 0;
                for (int s = 0; s < MT && !placed; s++) begin
                    lo = (ex0[s] - DT < 0) ? 0 : ex0[s] - DT;
                    if (ev[s] && x >= lo && x <= ex1[s] + DT && y <= ey1[s] + DT) begin
                        if (x < ex0[s]) ex0[s] = x;
                        if (x > ex1[s]) ex1[s] = x;
                        ey1[s] = y;
                        placed = 1;
                    end
                end
                for (int s = 0; s < MT && !placed; s++) begin
                    if (!ev[s]) begin
                        ev[s] = 1; ex0[s] = x; ex1[s] = x; ey0[s] = y; ey1[s] = y;
                        placed = 1;
                    end
                end
                if (!placed) eovf = 1;
            end
        end
        ecnt = 0;
        for (int s = 0; s < MT; s++) ecnt += ev[s];
    endtask

    task automatic drive_frame(int rows, int gap);
        int w, x;
        for (int g = 0; g < gap; g++) begin
            @(negedge sys_clk);
            vs = 1'b0; hr = (g == 1); ce = 1'b1; px_bit = 1'b1;
        end
        @(negedge sys_clk);
        vs = 1'b1; hr = 1'b0; ce = 1'b0; px_bit = 1'b0;
        for (int y = 0; y < rows; y++) begin
            w = rowmax[y] + 1 + $urandom_range(0, 3);
            if (w < 1) w = 1;
            x = 0;
            while (x < w) begin
                @(negedge sys_clk);
                hr = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    ce = 1'b0; px_bit = 1'($urandom_range(0, 1));
                end else begin
                    ce = 1'b1;
                    px_bit = fg.exists(y * 4096 + x) ? 1'b1 : 1'b0;
                    x++;
                end
            end
            repeat ($urandom_range(1, 3)) begin
                @(negedge sys_clk);
                hr = 1'b0; ce = 1'($urandom_range(0, 1)); px_bit = 1'($urandom_range(0, 1));
            end
        end
        @(negedge sys_clk);
        hr = 1'b0; ce = 1'b0; px_bit = 1'b0;
        checks++;
        if (box_valid !== 1'b0 || box_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_in_frame: valid=%b done=%b required 0/0", box_valid, box_done);
        end
    endtask

    task automatic end_frame();
        @(negedge sys_clk);
        vs = 1'b0; hr = 1'b0; ce = 1'b0; px_bit = 1'b0;
    endtask

    task automatic check_emission();
        for (int i = 0; i < MT; i++) begin
            @(negedge sys_clk);
            checks++;
            if (box_valid !== 1'(ev[i]) || box_done !== 1'b0) begin
                errors++;
                $display("FAIL rec%0d_valid: valid=%b done=%b required %0d/0", i, box_valid, box_done, ev[i]);
            end
            checks++;
            if (ev[i]) begin
                if ({box_idx, box_xmin, box_xmax, box_ymin, box_ymax} !==
                    {3'(i), 11'(ex0[i]), 11'(ex1[i]), 11'(ey0[i]), 11'(ey1[i])}) begin
                    errors++;
                    $display("FAIL rec%0d_box: got idx%0d (%0d,%0d,%0d,%0d) required idx%0d (%0d,%0d,%0d,%0d)",
                             i, box_idx, box_xmin, box_xmax, box_ymin, box_ymax,
                             i, ex0[i], ex1[i], ey0[i], ey1[i]);
                end
            end else if ({box_xmin, box_xmax, box_ymin, box_ymax} !== 44'd0) begin
                errors++;
                $display("FAIL rec%0d_empty: got (%0d,%0d,%0d,%0d) required zeros",
                         i, box_xmin, box_xmax, box_ymin, box_ymax);
            end
        end
        @(negedge sys_clk);
        checks++;
        if (box_done !== 1'b1 || box_valid !== 1'b0 || box_cnt !== 4'(ecnt) || box_overflow !== 1'(eovf)) begin
            errors++;
            $display("FAIL done: done=%b valid=%b cnt=%0d ovf=%b required 1/0/%0d/%0d",
                     box_done, box_valid, box_cnt, box_overflow, ecnt, eovf);
        end
        @(negedge sys_clk);
        checks++;
        if (box_done !== 1'b0 || box_cnt !== 4'd0 || box_overflow !== 1'b0 || box_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_done: done=%b cnt=%0d ovf=%b valid=%b required zeros",
                     box_done, box_cnt, box_overflow, box_valid);
        end
    endtask

    task automatic run_frame();
        run_model();
        drive_frame(maxrow + 2, $urandom_range(2, 4));
        end_frame();
        check_emission();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({box_valid, box_idx, box_xmin, box_xmax, box_ymin, box_ymax,
             box_done, box_cnt, box_overflow} !== '0) begin
            errors++;
            $display("FAIL reset: outputs not all zero (valid=%b done=%b cnt=%0d)", box_valid, box_done, box_cnt);
        end
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_single_box();
        clear_fg(); add_rect(100, 109, 50, 59); run_frame();
    endtask

    task automatic test_two_boxes();
        clear_fg(); add_rect(100, 109, 50, 59); add_rect(300, 309, 50, 59); run_frame();
    endtask

    task automatic test_merge();
        clear_fg(); set_px(100, 50); set_px(116, 50); run_frame();
        clear_fg(); set_px(100, 50); set_px(117, 50); run_frame();
        clear_fg(); set_px(100, 50); set_px(100, 67); run_frame();
    endtask

    task automatic test_overflow();
        clear_fg();
        for (int b = 0; b < 5; b++) add_rect(b * 100, b * 100 + 3, 10, 13);
        run_frame();
    endtask

    task automatic test_empty();
        clear_fg(); run_frame();
    endtask

    task automatic test_bounds();
        clear_fg();
        set_px(639, 0); set_px(640, 0); set_px(645, 0);
        set_px(0, 479); set_px(0, 480);
        run_frame();
    endtask

    task automatic test_refall();
        clear_fg(); add_rect(5, 8, 2, 4); run_model();
        drive_frame(maxrow + 2, 3);
        end_frame();
        @(negedge sys_clk);
        checks++;
        if (box_valid !== 1'(ev[0])) begin
            errors++;
            $display("FAIL refall_rec0: valid=%b required %0d", box_valid, ev[0]);
        end
        @(negedge sys_clk);
        vs = 1'b1;
        @(negedge sys_clk);
        vs = 1'b0;
        checks++;
        if (box_done !== 1'b0) begin
            errors++;
            $display("FAIL refall_nodone: done=%b required 0", box_done);
        end
        clear_fg(); run_model();
        check_emission();
    endtask

    task automatic test_reset_emission();
        int seen;
        clear_fg(); add_rect(40, 49, 5, 9); run_model();
        drive_frame(maxrow + 2, 2);
        end_frame();
        @(negedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if (box_valid !== 1'b0 || box_idx !== 3'd1) begin
            errors++;
            $display("FAIL rst_rec1: valid=%b idx=%0d required 0/1", box_valid, box_idx);
        end
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        checks++;
        if ({box_valid, box_idx, box_xmin, box_xmax, box_ymin, box_ymax,
             box_done, box_cnt, box_overflow} !== '0) begin
            errors++;
            $display("FAIL rst_mid: outputs not zero (valid=%b idx=%0d done=%b)", box_valid, box_idx, box_done);
        end
        seen = 0;
        repeat (8) begin
            @(negedge sys_clk);
            if (box_done !== 1'b0) seen = 1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_nodone: box_done seen=%0d required 0", seen);
        end
        clear_fg(); add_rect(20, 25, 3, 6); run_frame();
    endtask

    task automatic test_back_to_back();
        clear_fg(); add_rect(10, 19, 1, 4); add_rect(60, 62, 2, 3); run_model();
        drive_frame(maxrow + 2, 2);
        end_frame();
        clear_fg(); add_rect(30, 33, 4, 7);
        fork
            check_emission();
            drive_frame(maxrow + 2, 0);
        join
        run_model();
        end_frame();
        check_emission();
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            clear_fg();
            repeat ($urandom_range(1, 6)) begin
                int x0, y0;
                x0 = $urandom_range(0, 150);
                y0 = $urandom_range(0, 30);
                add_rect(x0, x0 + $urandom_range(0, 11), y0, y0 + $urandom_range(0, 7));
            end
            repeat (10) set_px($urandom_range(0, 160), $urandom_range(0, 38));
            run_frame();
        end
    endtask

    initial begin
        clear_fg();
        test_reset();
        test_single_box();
        test_two_boxes();
        test_merge();
        test_overflow();
        test_empty();
        test_bounds();
        test_refall();
        test_reset_emission();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
